// File: rtl/ysyx_25040129_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the funct3 encodings for memory operations, the LSU FSM state
// encoding, the AXI response codes and the default register and CSR
// index widths.
package ysyx_25040129_lsu_pkg;

    localparam int REGS_DIG_DEFAULT = 4;
    localparam int CSR_DIG_DEFAULT  = 12;

    // funct3 encodings of loads and stores
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // The low two funct3 bits give the access size.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_OUT     = 3'd5
    } lsu_state_e;

endpackage

// File: rtl/ysyx_25040129_lsu_align.sv
// Byte-lane alignment for the LSU, purely combinational.
// Store side: mem_op, addr_lo, store_data -> wdata, wstrb, misaligned.
// Load side:  mem_op, addr_lo, rdata      -> load_result (shifted down to
//             bit 0 and sign/zero extended).
module ysyx_25040129_lsu_align
    import ysyx_25040129_lsu_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned,
    output logic [31:0] load_result
);

    logic [4:0]  shamt;
    logic [31:0] rshift;
    logic [3:0]  base_strb;

    assign shamt  = {addr_lo, 3'b000};
    assign wdata  = store_data << shamt;
    assign rshift = rdata >> shamt;
    assign wstrb  = base_strb << addr_lo;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        base_strb  = 4'b1111;
        misaligned = 1'b0;
        case (mem_op[1:0])
            SIZE_B:  base_strb = 4'b0001;
            SIZE_H: begin
                base_strb  = 4'b0011;
                misaligned = addr_lo[0];
            end
            default: misaligned = |addr_lo;  // word (and unused size 11)
        endcase
    end

    always_comb begin
        load_result = rshift;
        case (mem_op)
            MEM_B:   load_result = {{24{rshift[7]}}, rshift[7:0]};
            MEM_BU:  load_result = {24'b0, rshift[7:0]};
            MEM_H:   load_result = {{16{rshift[15]}}, rshift[15:0]};
            MEM_HU:  load_result = {16'b0, rshift[15:0]};
            default: load_result = rshift;
        endcase
    end

endmodule

// File: rtl/ysyx_25040129_lsu.sv
// Load/store stage of the multi-cycle RV32 core (EXU -> LSU -> WBU).
// Upstream:   is_req_valid_from_exu / is_req_ready_to_exu plus the decoded
//             instruction fields (*_in_lsu).
// Downstream: is_req_valid_to_wbu / is_req_ready_from_wbu plus registered
//             result and writeback controls (*_out_lsu), access fault flag.
// Forwarding: is_data_forward_valid_from_lsu / lsu_forward_data.
// Memory:     AXI4-Lite master, one outstanding transaction at a time.
module ysyx_25040129_lsu
    import ysyx_25040129_lsu_pkg::*;
#(
    parameter int REGS_DIG = REGS_DIG_DEFAULT,
    parameter int CSR_DIG  = CSR_DIG_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                is_req_valid_from_exu,
    output logic                is_req_ready_to_exu,
    input  logic [REGS_DIG-1:0] rd_in_lsu,
    input  logic [31:0]         result_in_lsu,
    input  logic [31:0]         store_data_in_lsu,
    input  logic [2:0]          mem_op_in_lsu,
    input  logic                mem_read_in_lsu,
    input  logic                mem_write_in_lsu,
    input  logic [CSR_DIG-1:0]  csr_addr_in_lsu,
    input  logic                csr_write_in_lsu,
    input  logic                reg_write_in_lsu,
    input  logic                ebreak_in_lsu,
    output logic                is_req_valid_to_wbu,
    input  logic                is_req_ready_from_wbu,
    output logic [REGS_DIG-1:0] rd_out_lsu,
    output logic [31:0]         result_out_lsu,
    output logic [CSR_DIG-1:0]  csr_addr_out_lsu,
    output logic                csr_write_out_lsu,
    output logic                reg_write_out_lsu,
    output logic                ebreak_out_lsu,
    output logic                access_fault_out_lsu,
    output logic                is_data_forward_valid_from_lsu,
    output logic [31:0]         lsu_forward_data,
    output logic [31:0]         araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [31:0]         awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    lsu_state_e  state, state_next;
    logic [2:0]  mem_op_q;
    logic        reg_write_q, csr_write_q;
    logic        accept, is_mem, misaligned, aw_done, w_done;
    logic [2:0]  align_op;
    logic [1:0]  align_lo;
    logic [31:0] align_wdata, load_result;
    logic [3:0]  align_wstrb;

    assign is_req_ready_to_exu = (state == S_IDLE);
    assign accept              = is_req_valid_from_exu && is_req_ready_to_exu;
    assign is_mem              = mem_read_in_lsu || mem_write_in_lsu;
    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done             = !awvalid || awready;
    assign w_done              = !wvalid || wready;

    // In IDLE the aligner looks at the incoming instruction; afterwards at
    // the latched one (result_out_lsu holds the address until the load returns).
    assign align_op = (state == S_IDLE) ? mem_op_in_lsu : mem_op_q;
    assign align_lo = (state == S_IDLE) ? result_in_lsu[1:0] : result_out_lsu[1:0];

    ysyx_25040129_lsu_align u_align (
        .mem_op      (align_op),
        .addr_lo     (align_lo),
        .store_data  (store_data_in_lsu),
        .rdata       (rdata),
        .wdata       (align_wdata),
        .wstrb       (align_wstrb),
        .misaligned  (misaligned),
        .load_result (load_result)
    );

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) begin
                if (is_mem && misaligned) state_next = S_OUT;
                else if (mem_read_in_lsu) state_next = S_RD_ADDR;
                else if (mem_write_in_lsu) state_next = S_WR_REQ;
                else                       state_next = S_OUT;
            end
            S_RD_ADDR: if (arready)           state_next = S_RD_DATA;
            S_RD_DATA: if (rvalid)            state_next = S_OUT;
            S_WR_REQ:  if (aw_done && w_done) state_next = S_WR_RESP;
            S_WR_RESP: if (bvalid)            state_next = S_OUT;
            S_OUT:     if (is_req_ready_from_wbu) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // NOTE: there is no storage array here; every register, datapath included,
    // is cleared by reset so the outputs read 0 after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_req_valid_to_wbu  <= 1'b0;
            arvalid              <= 1'b0;
            awvalid              <= 1'b0;
            wvalid               <= 1'b0;
            rready               <= 1'b0;
            bready               <= 1'b0;
            access_fault_out_lsu <= 1'b0;
            result_out_lsu       <= '0;
            rd_out_lsu           <= '0;
            csr_addr_out_lsu     <= '0;
            ebreak_out_lsu       <= 1'b0;
            reg_write_q          <= 1'b0;
            csr_write_q          <= 1'b0;
            mem_op_q             <= '0;
            araddr               <= '0;
            awaddr               <= '0;
            wdata                <= '0;
            wstrb                <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    rd_out_lsu           <= rd_in_lsu;
                    result_out_lsu       <= result_in_lsu;
                    csr_addr_out_lsu     <= csr_addr_in_lsu;
                    ebreak_out_lsu       <= ebreak_in_lsu;
                    mem_op_q             <= mem_op_in_lsu;
                    reg_write_q          <= reg_write_in_lsu;
                    csr_write_q          <= csr_write_in_lsu;
                    access_fault_out_lsu <= 1'b0;
                    araddr               <= {result_in_lsu[31:2], 2'b00};
                    awaddr               <= {result_in_lsu[31:2], 2'b00};
                    wdata                <= align_wdata;
                    wstrb                <= align_wstrb;
                    if (is_mem && misaligned) begin
                        access_fault_out_lsu <= 1'b1;
                        reg_write_q          <= 1'b0;
                        csr_write_q          <= 1'b0;
                        is_req_valid_to_wbu  <= 1'b1;
                    end else if (mem_read_in_lsu) begin
                        arvalid <= 1'b1;
                    end else if (mem_write_in_lsu) begin
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end else begin
                        is_req_valid_to_wbu <= 1'b1;
                    end
                end
                S_RD_ADDR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                end
                S_RD_DATA: if (rvalid) begin
                    rready              <= 1'b0;
                    result_out_lsu      <= load_result;
                    is_req_valid_to_wbu <= 1'b1;
                    if (rresp != RESP_OKAY) begin
                        access_fault_out_lsu <= 1'b1;
                        reg_write_q          <= 1'b0;
                    end
                end
                S_WR_REQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if (aw_done && w_done) bready <= 1'b1;
                end
                S_WR_RESP: if (bvalid) begin
                    bready              <= 1'b0;
                    is_req_valid_to_wbu <= 1'b1;
                    if (bresp != RESP_OKAY) begin
                        access_fault_out_lsu <= 1'b1;
                        reg_write_q          <= 1'b0;
                    end
                end
                S_OUT: if (is_req_ready_from_wbu) is_req_valid_to_wbu <= 1'b0;
                default: ;
            endcase
        end
    end

    assign reg_write_out_lsu              = reg_write_q && is_req_valid_to_wbu;
    assign csr_write_out_lsu              = csr_write_q && is_req_valid_to_wbu;
    assign is_data_forward_valid_from_lsu = is_req_valid_to_wbu && reg_write_out_lsu;
    assign lsu_forward_data               = result_out_lsu;

endmodule
